// File: rtl/nand_cpu_pkg.sv
// ---------------------------------------------------------------------------
// nand_cpu_pkg
// Shared types for the data-memory path.
//   MEM_OP      : memory operation encoding used by requesters and d_cache
//   ARB_STATE   : d_mem_arbiter transaction state
//   NUM_MEM_REQ : number of requesters sharing the data-memory port
// ---------------------------------------------------------------------------
package nand_cpu_pkg;

    localparam int NUM_MEM_REQ = 2;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } MEM_OP;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ERR   = 2'd3
    } ARB_STATE;

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin pick. The grant is combinational from req_valid and the
// registered last winner; the last winner only moves when the grant is
// actually accepted.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (last winner -> 1)
//   req_valid  : per-requester request valid
//   accept     : the current grant is taken this cycle
//   grant      : one-hot winner, or zero when nobody requests
// ---------------------------------------------------------------------------
module rr_arbiter_2
    import nand_cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MEM_REQ-1:0] req_valid,
    input  logic                   accept,
    output logic [NUM_MEM_REQ-1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    // Winner selection: a sole requester always wins, a tie goes to the one
    // that did not win last time.
    always_comb begin
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (accept) begin
            last_grant_d = grant[1];
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-winner register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/d_mem_arbiter.sv
// ---------------------------------------------------------------------------
// d_mem_arbiter
// Shares the single d_cache port between the pipeline MEM stage (req 0) and
// the loader/debug port (req 1). Round-robin grant, one transaction in
// flight, response routed back to the owner, timeout reported as an error.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : per-requester handshake (ready is one-hot or zero)
//   req_addr/op/wdata : per-requester request fields, sampled on accept
//   resp_valid      : per-requester single-cycle response pulse
//   resp_data/err   : shared response payload, valid with resp_valid
//   mem_*           : request to d_cache (mem_valid is a one-cycle pulse)
//   mem_resp_*      : d_cache response
//   busy            : a transaction is in progress
// ---------------------------------------------------------------------------
module d_mem_arbiter
    import nand_cpu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_MEM_REQ-1:0]             req_valid,
    output logic [NUM_MEM_REQ-1:0]             req_ready,
    input  logic [NUM_MEM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  MEM_OP [NUM_MEM_REQ-1:0]            req_op,
    input  logic [NUM_MEM_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_MEM_REQ-1:0]             resp_valid,
    output logic [DATA_W-1:0]                  resp_data,
    output logic                               resp_err,
    output logic                               mem_valid,
    output logic [ADDR_W-1:0]                  mem_addr,
    output MEM_OP                              mem_op,
    output logic [DATA_W-1:0]                  mem_wdata,
    input  logic                               mem_resp_valid,
    input  logic [DATA_W-1:0]                  mem_resp_data,
    output logic                               busy
);

    // A zero TIMEOUT still needs a one-bit timer to keep the logic legal.
    localparam int             TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  TIMEOUT_V = TW'(TIMEOUT);
    localparam logic [TW-1:0]  TIMER_MAX = {TW{1'b1}};
    localparam bit             TO_EN     = (TIMEOUT != 0);

    ARB_STATE          state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    MEM_OP             op_q,    op_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic [NUM_MEM_REQ-1:0] grant_s;
    logic                   win_idx_s;
    logic                   accept_s;

    // Accept only from IDLE and never while reset is asserted.
    assign accept_s  = (state_q == ARB_IDLE) && (|req_valid) && !rst;
    assign win_idx_s = grant_s[1];

    rr_arbiter_2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .accept    (accept_s),
        .grant     (grant_s)
    );

    // Next-state, held-request and output decode.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        timer_d    = timer_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        resp_data  = {DATA_W{1'b0}};
        resp_err   = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = {ADDR_W{1'b0}};
        mem_op     = MEM_NONE;
        mem_wdata  = {DATA_W{1'b0}};

        if (!rst) begin
            case (state_q)
                ARB_IDLE: begin
                    // Stray mem_resp_valid here is deliberately ignored.
                    if (accept_s) begin
                        req_ready = grant_s;
                        owner_d   = win_idx_s;
                        addr_d    = req_addr[win_idx_s];
                        op_d      = req_op[win_idx_s];
                        wdata_d   = req_wdata[win_idx_s];
                        timer_d   = {TW{1'b0}};
                        // A no-op request never reaches memory; it is
                        // answered with an error on the next cycle.
                        if (req_op[win_idx_s] == MEM_NONE) begin
                            state_d = ARB_ERR;
                        end else begin
                            state_d = ARB_ISSUE;
                        end
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end

                ARB_ISSUE: begin
                    mem_valid = 1'b1;
                    mem_addr  = addr_q;
                    mem_op    = op_q;
                    mem_wdata = wdata_q;
                    if (mem_resp_valid) begin
                        resp_valid[owner_q] = 1'b1;
                        resp_data = (op_q == MEM_LOAD) ? mem_resp_data : {DATA_W{1'b0}};
                        state_d   = ARB_IDLE;
                    end else begin
                        timer_d = TW'(1);
                        state_d = ARB_WAIT;
                    end
                end

                ARB_WAIT: begin
                    // A response arriving on the timeout cycle still counts
                    // as a good completion.
                    if (mem_resp_valid) begin
                        resp_valid[owner_q] = 1'b1;
                        resp_data = (op_q == MEM_LOAD) ? mem_resp_data : {DATA_W{1'b0}};
                        state_d   = ARB_IDLE;
                    end else if (TO_EN && (timer_q == TIMEOUT_V)) begin
                        resp_valid[owner_q] = 1'b1;
                        resp_err  = 1'b1;
                        state_d   = ARB_IDLE;
                    end else begin
                        // Saturating count so the timer can never wrap.
                        if (timer_q != TIMER_MAX) begin
                            timer_d = timer_q + TW'(1);
                        end else begin
                            timer_d = timer_q;
                        end
                        state_d = ARB_WAIT;
                    end
                end

                ARB_ERR: begin
                    resp_valid[owner_q] = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = ARB_IDLE;
                end

                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
        end else begin
            state_d = ARB_IDLE;
        end
    end

    // State, held request and timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            op_q    <= MEM_NONE;
            wdata_q <= {DATA_W{1'b0}};
            timer_q <= {TW{1'b0}};
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            timer_q <= timer_d;
        end
    end

    assign busy = (state_q != ARB_IDLE);

endmodule
